conv_pe_sequencer: RTL and testbench

// Parametrised next-generation control FSM for the convolution PE; it sits between the IFMAP/filter buffers,
// the multiply/accumulate datapath and the psum buffer. It sequences FILT_LEN items per filter and NUM_FILTERS

---
 rtl/conv_pe_sequencer.sv | 173 +++++++++++++++++
 tb/tb_conv_pe_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_sequencer.sv
// conv_pe_sequencer
//   Control FSM for the convolution PE. It issues FILT_LEN IFMAP/filter reads
//   per filter and NUM_FILTERS filters per window, tracks the multiply/
//   accumulate pipe with a valid shift register, drains it, then reads
//   (optionally) and writes one psum per filter. Any external fault parks the
//   block in ERR until reset.
// Ports
//   clk, reset_n                         clock, async active-low reset
//   start, cfg_filt_len, cfg_num_filters,
//   cfg_psum_mode                        job launch + config (sampled in IDLE)
//   if_valid, filt_valid                 operand availability
//   last_window                          final window of the job
//   psum_rd_valid, wr_ready              psum buffer handshakes
//   error                                external fault
//   ren, mult_en, acc_en, acc_clr        datapath strobes
//   item_idx, filt_idx, psum_addr        indices / psum address
//   psum_ren, psum_wen, add_psum         psum buffer controls
//   next_window, done, busy, stall_err   job status
module conv_pe_sequencer #(
  parameter int FILTER_ADDR_WIDTH = 8,
  parameter int NF_WIDTH          = 4,
  parameter int PSUM_ADDR_WIDTH   = 6,
  parameter int MULT_LAT          = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [FILTER_ADDR_WIDTH-1:0] cfg_filt_len,
  input  logic [NF_WIDTH-1:0]          cfg_num_filters,
  input  logic                         cfg_psum_mode,
  input  logic                         if_valid,
  input  logic                         filt_valid,
  input  logic                         last_window,
  input  logic                         psum_rd_valid,
  input  logic                         wr_ready,
  input  logic                         error,
  output logic                         ren,
  output logic                         mult_en,
  output logic                         acc_en,
  output logic                         acc_clr,
  output logic [FILTER_ADDR_WIDTH-1:0] item_idx,
  output logic [NF_WIDTH-1:0]          filt_idx,
  output logic                         psum_ren,
  output logic                         psum_wen,
  output logic                         add_psum,
  output logic [PSUM_ADDR_WIDTH-1:0]   psum_addr,
  output logic                         next_window,
  output logic                         busy,
  output logic                         done,
  output logic                         stall_err
);
  localparam int FAW = FILTER_ADDR_WIDTH;
  localparam int NFW = NF_WIDTH;
  localparam int PAW = PSUM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, INIT, RUN, DRAIN, PSUM_RD, PSUM_WR, NEXT_WIN, ERR
  } state_t;

  state_t state, state_nxt;

  logic [FAW-1:0]    len_q;
  logic [NFW-1:0]    nf_q;
  logic              mode_q;
  logic [FAW-1:0]    item_q;
  logic [NFW-1:0]    filt_q;
  logic [PAW-1:0]    addr_q;
  logic [MULT_LAT:0] vld_pipe;   // bit k set = issue happened k+1 cycles ago

  logic issue, last_item, last_filt, cfg_bad, launch, wr_accept;

  assign last_item = (item_q == len_q - FAW'(1));
  assign last_filt = (filt_q == nf_q - NFW'(1));
  assign cfg_bad   = (cfg_filt_len == '0) || (cfg_num_filters == '0);
  assign launch    = (state == IDLE) && start && !error;
  assign wr_accept = psum_wen && wr_ready;

  // A faulting cycle suppresses every strobe and transition so that no
  // counter or buffer side effect lands in the same cycle as the fault.
  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    ren         = 1'b0;
    acc_clr     = 1'b0;
    psum_ren    = 1'b0;
    psum_wen    = 1'b0;
    add_psum    = 1'b0;
    next_window = 1'b0;
    done        = 1'b0;
    if (error) begin
      state_nxt = ERR;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = cfg_bad ? ERR : INIT;
        INIT: begin
          acc_clr   = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          issue = if_valid && filt_valid;
          ren   = issue;
          if (issue && last_item) state_nxt = DRAIN;
        end
        DRAIN:   if (vld_pipe == '0) state_nxt = mode_q ? PSUM_RD : PSUM_WR;
        PSUM_RD: begin
          psum_ren = 1'b1;
          if (psum_rd_valid) state_nxt = PSUM_WR;
        end
        PSUM_WR: begin
          psum_wen = 1'b1;
          add_psum = mode_q;
          if (wr_ready) begin
            acc_clr   = 1'b1;
            state_nxt = last_filt ? NEXT_WIN : RUN;
          end
        end
        NEXT_WIN: begin
          if (last_window) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            next_window = 1'b1;
            state_nxt   = RUN;
          end
        end
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      len_q     <= '0;
      nf_q      <= '0;
      mode_q    <= 1'b0;
      item_q    <= '0;
      filt_q    <= '0;
      addr_q    <= '0;
      vld_pipe  <= '0;
      stall_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Shifts every cycle: stalls become bubbles instead of freezing the pipe.
      vld_pipe <= {vld_pipe[MULT_LAT-1:0], issue};
      if (state_nxt == ERR) stall_err <= 1'b1;
      if (launch) begin
        len_q  <= cfg_filt_len;
        nf_q   <= cfg_num_filters;
        mode_q <= cfg_psum_mode;
        item_q <= '0;
        filt_q <= '0;
        addr_q <= '0;
      end
      // Hold on the final item so item_idx never wraps past filt_len-1.
      if (issue && !last_item) item_q <= item_q + FAW'(1);
      if (wr_accept) begin
        item_q <= '0;
        addr_q <= addr_q + PAW'(1);
        filt_q <= last_filt ? '0 : filt_q + NFW'(1);
      end
    end
  end

  assign item_idx  = item_q;
  assign filt_idx  = filt_q;
  assign psum_addr = addr_q;
  assign busy      = (state != IDLE);
  assign mult_en   = vld_pipe[0] && (state != ERR);
  assign acc_en    = vld_pipe[MULT_LAT] && (state != ERR);

endmodule

// File: tb/tb_conv_pe_sequencer.sv
module tb_conv_pe_sequencer;
  logic clk, reset_n;
  logic start, start1, cfg_psum_mode, if_valid, filt_valid, last_window;
  logic psum_rd_valid, wr_ready, error;
  logic [7:0] cfg_filt_len;
  logic [3:0] cfg_num_filters;

  // main DUT: MULT_LAT=2, 2-bit psum address
  logic ren, mult_en, acc_en, acc_clr, psum_ren, psum_wen, add_psum;
  logic next_window, busy, done, stall_err;
  logic [7:0] item_idx;
  logic [3:0] filt_idx;
  logic [1:0] psum_addr;

  // second DUT: default parameters
  logic ren1, mult_en1, acc_en1, acc_clr1, psum_ren1, psum_wen1, add_psum1;
  logic next_window1, busy1, done1, stall_err1;
  logic [7:0] item_idx1;
  logic [3:0] filt_idx1;
  logic [5:0] psum_addr1;

  conv_pe_sequencer #(.MULT_LAT(2), .PSUM_ADDR_WIDTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_filt_len(cfg_filt_len),
    .cfg_num_filters(cfg_num_filters), .cfg_psum_mode(cfg_psum_mode),
    .if_valid(if_valid), .filt_valid(filt_valid), .last_window(last_window),
    .psum_rd_valid(psum_rd_valid), .wr_ready(wr_ready), .error(error),
    .ren(ren), .mult_en(mult_en), .acc_en(acc_en), .acc_clr(acc_clr),
    .item_idx(item_idx), .filt_idx(filt_idx), .psum_ren(psum_ren),
    .psum_wen(psum_wen), .add_psum(add_psum), .psum_addr(psum_addr),
    .next_window(next_window), .busy(busy), .done(done), .stall_err(stall_err));

  conv_pe_sequencer dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .cfg_filt_len(cfg_filt_len),
    .cfg_num_filters(cfg_num_filters), .cfg_psum_mode(cfg_psum_mode),
    .if_valid(if_valid), .filt_valid(filt_valid), .last_window(last_window),
    .psum_rd_valid(psum_rd_valid), .wr_ready(wr_ready), .error(error),
    .ren(ren1), .mult_en(mult_en1), .acc_en(acc_en1), .acc_clr(acc_clr1),
    .item_idx(item_idx1), .filt_idx(filt_idx1), .psum_ren(psum_ren1),
    .psum_wen(psum_wen1), .add_psum(add_psum1), .psum_addr(psum_addr1),
    .next_window(next_window1), .busy(busy1), .done(done1), .stall_err(stall_err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0, n_checks = 0;

  // job statistics, cycle numbers are relative to the start cycle (c=0)
  int n_ren, n_mult, n_acc, n_clr, n_prd, n_wen, n_nw, n_done, n_done1;
  int first_acc, first_wen, first_prd, first_ren, done_cyc, last3_cyc;
  int ren1_cyc, acc1_cyc, wr1_cyc;
  int ren_items[$], wr_addrs[$], wr_add[$], wr_filt[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 0; start1 = 0; error = 0;
    if_valid = 0; filt_valid = 0; last_window = 0; psum_rd_valid = 0; wr_ready = 0;
    cfg_filt_len = 0; cfg_num_filters = 0; cfg_psum_mode = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Runs one job on the main DUT (and optionally dut1). The psum buffer
  // answers reads after rd_dly cycles of psum_ren and writes after wr_dly
  // cycles of psum_wen; config is zeroed/flipped after the start cycle.
  task automatic job(input int len, input int nf, input int mode, input int rd_dly,
                     input int wr_dly, input bit toggle, input int last_on,
                     input bit use1, input int maxc);
    int rd_s, wr_s;
    logic [7:0] l8; logic [3:0] n4; logic [31:0] m32;
    rd_s = 0; wr_s = 0;
    l8 = len[7:0]; n4 = nf[3:0]; m32 = mode;
    n_ren = 0; n_mult = 0; n_acc = 0; n_clr = 0; n_prd = 0; n_wen = 0; n_nw = 0;
    n_done = 0; n_done1 = 0;
    first_acc = -1; first_wen = -1; first_prd = -1; first_ren = -1; done_cyc = -1;
    last3_cyc = -1; ren1_cyc = -1; acc1_cyc = -1; wr1_cyc = -1;
    ren_items.delete(); wr_addrs.delete(); wr_add.delete(); wr_filt.delete();
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      start  = (c == 0);
      start1 = use1 && (c == 0);
      if (c == 0) begin
        cfg_filt_len = l8; cfg_num_filters = n4; cfg_psum_mode = m32[0];
      end else begin
        cfg_filt_len = 8'd0; cfg_num_filters = 4'd0; cfg_psum_mode = ~m32[0];
      end
      if_valid      = toggle ? (c % 2 == 0) : 1'b1;
      filt_valid    = 1'b1;
      last_window   = (n_nw >= last_on - 1);
      psum_rd_valid = (rd_s >= rd_dly);
      wr_ready      = (wr_s >= wr_dly);
      #1;
      if (ren) begin
        n_ren++; ren_items.push_back(int'(item_idx));
        if (first_ren < 0) first_ren = c;
        if (item_idx == 8'd3) last3_cyc = c;
      end
      if (mult_en) n_mult++;
      if (acc_en) begin n_acc++; if (first_acc < 0) first_acc = c; end
      if (acc_clr) n_clr++;
      if (psum_ren) begin
        n_prd++; if (first_prd < 0) first_prd = c;
        rd_s = psum_rd_valid ? 0 : rd_s + 1;
      end
      if (psum_wen) begin
        n_wen++; if (first_wen < 0) first_wen = c;
        if (wr_ready) begin
          wr_addrs.push_back(int'(psum_addr)); wr_add.push_back(int'(add_psum));
          wr_filt.push_back(int'(filt_idx)); wr_s = 0;
        end else wr_s++;
      end
      if (next_window) n_nw++;
      if (ren1 && ren1_cyc < 0) ren1_cyc = c;
      if (acc_en1 && acc1_cyc < 0) acc1_cyc = c;
      if (psum_wen1 && wr_ready && wr1_cyc < 0) wr1_cyc = c;
      if (done1) n_done1++;
      if (done) begin n_done++; done_cyc = c; break; end
    end
    start = 0; start1 = 0; if_valid = 0; filt_valid = 0;
    chk("job_finished", 32'(done_cyc >= 0), 1);
    @(negedge clk); #1;
    chk("idle_after_job", 32'(busy), 0);
  endtask

  initial begin
    do_reset();
    // reset state (checked while reset still low would also hold; check after)
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall_err", 32'(stall_err), 0);
    chk("rst_psum_addr", 32'(psum_addr), 0);
    chk("rst_item_idx", 32'(item_idx), 0);
    chk("rst_outs", 32'({ren, mult_en, acc_en, acc_clr, psum_ren, psum_wen, done}), 0);

    // len=3, nf=2, overwrite, everything ready
    job(3, 2, 0, 0, 0, 1'b0, 1, 1'b0, 100);
    chk("t1_ren", n_ren, 6);
    chk("t1_mult", n_mult, 6);
    chk("t1_acc", n_acc, 6);
    chk("t1_clr", n_clr, 3);
    chk("t1_done", n_done, 1);
    chk("t1_done_cyc", done_cyc, 18);
    chk("t1_first_acc", first_acc, 5);
    chk("t1_first_wen", first_wen, 9);
    chk("t1_nwr", wr_addrs.size(), 2);
    if (wr_addrs.size() == 2) begin
      chk("t1_addr0", wr_addrs[0], 0);
      chk("t1_addr1", wr_addrs[1], 1);
      chk("t1_filt1", wr_filt[1], 1);
      chk("t1_add0", wr_add[0], 0);
    end
    if (ren_items.size() == 6) chk("t1_item5", ren_items[5], 2);
    chk("t1_end_addr", 32'(psum_addr), 2);

    // len=1: latency 2 on main DUT, latency 1 on dut1
    job(1, 1, 0, 0, 0, 1'b0, 1, 1'b1, 100);
    chk("t2_ren_cyc", first_ren, 2);
    chk("t2_acc_cyc", first_acc, 5);
    chk("t2_acc", n_acc, 1);
    chk("t2_wen_cyc", first_wen, 7);
    chk("t2_ml1_ren", ren1_cyc, 2);
    chk("t2_ml1_acc", acc1_cyc, 4);
    chk("t2_ml1_wr", wr1_cyc, 6);
    chk("t2_ml1_done", n_done1, 1);

    // read-add-write, read data 4 cycles late
    job(2, 1, 1, 4, 0, 1'b0, 1, 1'b0, 100);
    chk("t3_prd_cyc", first_prd, 8);
    chk("t3_prd_len", n_prd, 5);
    chk("t3_wen_cyc", first_wen, 13);
    chk("t3_wen_len", n_wen, 1);
    if (wr_add.size() == 1) chk("t3_add_psum", wr_add[0], 1);
    else chk("t3_nwr", wr_add.size(), 1);
    chk("t3_done_cyc", done_cyc, 14);

    // bubbly operand stream, slow write
    job(4, 1, 0, 0, 3, 1'b1, 1, 1'b0, 100);
    chk("t4_ren", n_ren, 4);
    chk("t4_last_item_cyc", last3_cyc, 8);
    chk("t4_mult", n_mult, 4);
    chk("t4_wen_len", n_wen, 4);
    chk("t4_nwr", wr_addrs.size(), 1);
    if (ren_items.size() == 4) chk("t4_item2", ren_items[2], 2);
    chk("t4_done_cyc", done_cyc, 17);
    chk("t4_end_addr", 32'(psum_addr), 1);

    // five windows, psum address wraps 3 -> 0
    job(1, 1, 0, 0, 0, 1'b0, 5, 1'b0, 200);
    chk("t5_nw", n_nw, 4);
    chk("t5_done", n_done, 1);
    chk("t5_done_cyc", done_cyc, 36);
    chk("t5_nwr", wr_addrs.size(), 5);
    if (wr_addrs.size() == 5) begin
      chk("t5_addr3", wr_addrs[3], 3);
      chk("t5_addr4", wr_addrs[4], 0);
    end

    // fault during RUN
    @(negedge clk);
    start = 1; cfg_filt_len = 8'd4; cfg_num_filters = 4'd1; cfg_psum_mode = 0;
    if_valid = 1; filt_valid = 1; wr_ready = 1; last_window = 1;
    @(negedge clk); start = 0; #1;
    chk("t6_init_clr", 32'(acc_clr), 1);
    @(negedge clk); #1;
    chk("t6_run_ren", 32'(ren), 1);
    chk("t6_no_err_yet", 32'(stall_err), 0);
    @(negedge clk); error = 1;
    @(negedge clk); error = 0; start = 1; #1;
    chk("t6_stall_err", 32'(stall_err), 1);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_ren_off", 32'(ren), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t6_err_sticky", 32'(stall_err), 1);
      chk("t6_err_enables", 32'({ren, mult_en, acc_en, psum_wen, psum_ren}), 0);
    end
    reset_n = 0; #1;
    chk("t6_async_rst_busy", 32'(busy), 0);
    chk("t6_async_rst_err", 32'(stall_err), 0);
    start = 0;
    @(negedge clk); reset_n = 1;

    // zero filter length at start
    @(negedge clk);
    start = 1; cfg_filt_len = 8'd0; cfg_num_filters = 4'd2; if_valid = 1; filt_valid = 1;
    @(negedge clk); start = 0; #1;
    chk("t7_busy", 32'(busy), 1);
    chk("t7_no_init", 32'(acc_clr), 0);
    repeat (4) @(negedge clk);
    #1;
    chk("t7_stuck", 32'({busy, ren, done}), 32'b100);
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end
endmodule
